// File: rtl/matrix_multiplier_if.sv
// Operand/result bundle for the 2x2 matrix multiplier: packed A/B operands in, four products and done out.
interface matrix_multiplier_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned OP_W  = 4 * DATA_W;
  localparam int unsigned RES_W = 2 * DATA_W;

  logic             load;
  logic [OP_W-1:0]  nums_a;
  logic [OP_W-1:0]  nums_b;
  logic [RES_W-1:0] result1;
  logic [RES_W-1:0] result2;
  logic [RES_W-1:0] result3;
  logic [RES_W-1:0] result4;
  logic             matrix_multiplication_done;

  modport master (
    output load, nums_a, nums_b,
    input  result1, result2, result3, result4, matrix_multiplication_done
  );

  modport slave (
    input  load, nums_a, nums_b,
    output result1, result2, result3, result4, matrix_multiplication_done
  );
endinterface

// File: rtl/matrix_multiplier.sv
// Pipelined 2x2 unsigned matrix multiplier C = A x B: operand capture, multiply stage, add stage.
// Optional macro SATURATE_EN clamps overflowing sums to all ones instead of wrapping.
module matrix_multiplier #(
  parameter int unsigned DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  matrix_multiplier_if.slave  bus
);
  localparam int unsigned RES_W = 2 * DATA_W;

  // Element index: 0=x11, 1=x12, 2=x21, 3=x22 (row-wise, MSB first in the packed word)
  logic [DATA_W-1:0] op_a [4];
  logic [DATA_W-1:0] op_b [4];
  logic [RES_W-1:0]  prod [8];
  logic [RES_W-1:0]  prod_c [8];
  logic [RES_W-1:0]  sum_c [4];
  logic              pending;
  logic              valid1;
  logic              issue_c;

  function automatic logic [RES_W-1:0] add_pair(input logic [RES_W-1:0] x, input logic [RES_W-1:0] y);
`ifdef SATURATE_EN
    logic [RES_W:0] s;
    s = (RES_W+1)'(x) + (RES_W+1)'(y);
    return s[RES_W] ? {RES_W{1'b1}} : s[RES_W-1:0];
`else
    return RES_W'(x + y);
`endif
  endfunction

  // Operand registers: no reset, hold until the next load
  always_ff @(posedge clk) begin
    if (bus.load) begin
      for (int i = 0; i < 4; i++) begin
        op_a[i] <= bus.nums_a[(3-i)*DATA_W +: DATA_W];
        op_b[i] <= bus.nums_b[(3-i)*DATA_W +: DATA_W];
      end
    end
  end

  assign issue_c = !rst && !bus.load && pending;

  // Product pairs feeding each result element r = {row, col}
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      prod_c[2*r]   = RES_W'(op_a[2*(r/2)])     * RES_W'(op_b[r%2]);
      prod_c[2*r+1] = RES_W'(op_a[2*(r/2) + 1]) * RES_W'(op_b[2 + r%2]);
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      sum_c[r] = add_pair(prod[2*r], prod[2*r+1]);
    end
  end

  // Pending flag and stage 1 (multiply)
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b1;
      valid1  <= 1'b0;
      for (int i = 0; i < 8; i++) prod[i] <= '0;
    end else if (bus.load) begin
      pending <= 1'b1;
      valid1  <= 1'b0;
    end else if (issue_c) begin
      pending <= 1'b0;
      valid1  <= 1'b1;
      for (int i = 0; i < 8; i++) prod[i] <= prod_c[i];
    end else begin
      valid1  <= 1'b0;
    end
  end

  // Stage 2 (add); a load suppresses any in-flight write and clears done
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result1                    <= '0;
      bus.result2                    <= '0;
      bus.result3                    <= '0;
      bus.result4                    <= '0;
      bus.matrix_multiplication_done <= 1'b0;
    end else if (bus.load) begin
      bus.matrix_multiplication_done <= 1'b0;
    end else if (valid1) begin
      bus.result1                    <= sum_c[0];
      bus.result2                    <= sum_c[1];
      bus.result3                    <= sum_c[2];
      bus.result4                    <= sum_c[3];
      bus.matrix_multiplication_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_matrix_multiplier.sv
// Self-checking bench for matrix_multiplier: directed vector table, multi-cycle corner sequences, random vs. model.
module tb_matrix_multiplier;
  localparam int unsigned DATA_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  matrix_multiplier_if #(.DATA_W(DATA_W)) mm_if ();

  matrix_multiplier #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;
    logic [15:0] r4;
  } vec_t;

  vec_t vecs [6];

  // Reference: plain 2x2 matrix product on integers, then wrap or clamp to 16 bits
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea;
    logic [7:0]  eb;
    int unsigned am [2][2];
    int unsigned bm [2][2];
    int unsigned c;
    logic [63:0] res;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        ea = a[(3 - (2*i + j))*8 +: 8];
        eb = b[(3 - (2*i + j))*8 +: 8];
        am[i][j] = 32'(ea);
        bm[i][j] = 32'(eb);
      end
    end
    res = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        c = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
`ifdef SATURATE_EN
        if (c > 32'd65535) c = 32'd65535;
`else
        c = c % 32'd65536;
`endif
        res[(3 - (2*i + j))*16 +: 16] = 16'(c);
      end
    end
    return res;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic check_results(input string name, input logic [63:0] exp);
    check({name, " result1"}, mm_if.result1, exp[63:48]);
    check({name, " result2"}, mm_if.result2, exp[47:32]);
    check({name, " result3"}, mm_if.result3, exp[31:16]);
    check({name, " result4"}, mm_if.result4, exp[15:0]);
  endtask

  // Load for n cycles, drop load, confirm done is still low after the issue edge, land on the result cycle
  task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b, input int n);
    mm_if.load   = 1'b1;
    mm_if.nums_a = a;
    mm_if.nums_b = b;
    repeat (n) step();
    mm_if.load = 1'b0;
    step();
    check({name, " done after issue"}, 16'(mm_if.matrix_multiplication_done), 16'd0);
    step();
    check({name, " done"}, 16'(mm_if.matrix_multiplication_done), 16'd1);
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    errors = 0;

    vecs[0] = '{"basic",    32'h01020408, 32'h0103050B, 16'd11, 16'd25, 16'd44, 16'd100};
    vecs[1] = '{"identity", 32'h01000001, 32'h09080706, 16'd9,  16'd8,  16'd7,  16'd6};
`ifdef SATURATE_EN
    vecs[2] = '{"overflow", 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
    vecs[2] = '{"overflow", 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFC02, 16'hFC02, 16'hFC02, 16'hFC02};
`endif
    vecs[3] = '{"zeros",    32'h00000000, 32'hFFFFFFFF, 16'd0,  16'd0,  16'd0,  16'd0};
    vecs[4] = '{"reload",   32'h00000001, 32'h00000007, 16'd0,  16'd0,  16'd0,  16'd7};
    vecs[5] = '{"mixed",    32'h0A141E28, 32'h02030405, 16'd100, 16'd130, 16'd220, 16'd290};

    rst          = 1'b1;
    mm_if.load   = 1'b0;
    mm_if.nums_a = '0;
    mm_if.nums_b = '0;
    step();
    step();
    check_results("reset", 64'd0);
    check("reset done", 16'(mm_if.matrix_multiplication_done), 16'd0);

    // rst and load together: operands still captured, restart once both drop
    mm_if.load   = 1'b1;
    mm_if.nums_a = vecs[0].a;
    mm_if.nums_b = vecs[0].b;
    step();
    rst = 1'b0;
    apply("rst+load", vecs[0].a, vecs[0].b, 2);
    check_results("rst+load", {vecs[0].r1, vecs[0].r2, vecs[0].r3, vecs[0].r4});

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].name, vecs[i].a, vecs[i].b, 3);
      check_results(vecs[i].name, {vecs[i].r1, vecs[i].r2, vecs[i].r3, vecs[i].r4});
      repeat (3) step();
      check({vecs[i].name, " hold r1"}, mm_if.result1, vecs[i].r1);
      check({vecs[i].name, " hold done"}, 16'(mm_if.matrix_multiplication_done), 16'd1);
    end

    // Reset after load: results cleared, then recomputed from retained operands
    apply("pre-reset", vecs[0].a, vecs[0].b, 1);
    rst = 1'b1;
    step();
    check_results("in reset", 64'd0);
    check("in reset done", 16'(mm_if.matrix_multiplication_done), 16'd0);
    rst = 1'b0;
    step();
    check("post reset issue done", 16'(mm_if.matrix_multiplication_done), 16'd0);
    step();
    check("post reset done", 16'(mm_if.matrix_multiplication_done), 16'd1);
    check_results("post reset", {vecs[0].r1, vecs[0].r2, vecs[0].r3, vecs[0].r4});

    // Reload: done drops on the load edge, old results remain until overwritten
    mm_if.load   = 1'b1;
    mm_if.nums_a = vecs[4].a;
    mm_if.nums_b = vecs[4].b;
    step();
    check("reload edge done", 16'(mm_if.matrix_multiplication_done), 16'd0);
    check("reload edge old r4", mm_if.result4, vecs[0].r4);
    mm_if.load = 1'b0;
    step();
    step();
    check_results("reload", {vecs[4].r1, vecs[4].r2, vecs[4].r3, vecs[4].r4});

    // Load reasserted one cycle after issue: stage-2 write suppressed
    mm_if.load   = 1'b1;
    mm_if.nums_a = 32'hFFFFFFFF;
    mm_if.nums_b = 32'hFFFFFFFF;
    step();
    mm_if.load = 1'b0;
    step();
    mm_if.load   = 1'b1;
    mm_if.nums_a = 32'h02030405;
    mm_if.nums_b = 32'h01000001;
    step();
    check("suppressed done", 16'(mm_if.matrix_multiplication_done), 16'd0);
    check("suppressed r1 kept", mm_if.result1, vecs[4].r1);
    mm_if.load = 1'b0;
    step();
    check("reissue done", 16'(mm_if.matrix_multiplication_done), 16'd0);
    step();
    check("late load done", 16'(mm_if.matrix_multiplication_done), 16'd1);
    check_results("late load", {16'd2, 16'd3, 16'd4, 16'd5});

    // Random operands against the reference model
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 5 == 0) ra = ra | 32'hF0F0F0F0;
      exp = model(ra, rb);
      apply("random", ra, rb, 1 + int'($urandom_range(2)));
      check_results("random", exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
